fb_io_dev: RTL and testbench

//  Device-side responder for the external-device window (address bit 10 set).

---
 rtl/fb_io_pkg.sv | 24 ++
 rtl/fb_io_fifo.sv | 75 +++++++
 rtl/fb_io_dev.sv | 128 ++++++++++++
 tb/tb_fb_io_dev.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fb_io_pkg.sv
// fb_io_pkg: shared definitions for the external-device responder.
//   Select codes from the MMU, STATUS bit positions and the terminal FSM
//   state type. Imported by fb_io_dev and fb_io_fifo.
package fb_io_pkg;

    // MMU data-source select codes
    localparam logic [1:0] FB_SEL_STAT = 2'b00;
    localparam logic [1:0] FB_SEL_DATA = 2'b01;
    localparam logic [1:0] FB_SEL_TERM = 2'b10;
    localparam logic [1:0] FB_SEL_MEM  = 2'b11;

    // STATUS word bit positions
    localparam int FB_ST_AVAIL = 0;
    localparam int FB_ST_OVR   = 1;
    localparam int FB_ST_BUSY  = 2;
    localparam int FB_ST_DROP  = 3;
    localparam int FB_ST_W     = 4;

    typedef enum logic {
        TERM_IDLE = 1'b0,
        TERM_BUSY = 1'b1
    } term_state_e;

endpackage

// File: rtl/fb_io_fifo.sv
// fb_io_fifo: keyboard character FIFO.
//   clk, rst   : clock, synchronous active-high reset
//   push, din  : write request and character
//   pop        : read request (ignored when empty)
//   head       : oldest entry (valid when !empty)
//   full/empty : occupancy flags, count: 0..FIFO_DEPTH
//   lost       : push refused this cycle because no entry was free
module fb_io_fifo
    import fb_io_pkg::*;
#(
    parameter int CHAR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [CHAR_W-1:0]             din,
    output logic [CHAR_W-1:0]             head,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          lost
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CHAR_W-1:0] mem_q [FIFO_DEPTH];
    logic [CHAR_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok, pop_ok;

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // A pop on a full FIFO frees the slot the same-cycle push needs;
    // a pop on an empty FIFO does nothing, so the push goes in alone.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign lost    = push & ~push_ok;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;   // power-of-two depth wraps naturally
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fb_io_dev.sv
// fb_io_dev: device-side responder for the external-device window.
//   clk, rst            : clock, synchronous active-high reset
//   dev_sel, data_src   : window hit and MMU register select
//   rd_en, wr_en, wdata : MEM-stage load/store and store data
//   clr_stat            : clears sticky ovr/drop (delayed from a STATUS read)
//   rdata               : read data, combinational from registered state
//   kbd_stb, kbd_char   : keyboard character strobe (no backpressure)
//   term_valid/char/ready : terminal output handshake
module fb_io_dev
    import fb_io_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int CHAR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dev_sel,
    input  logic [1:0]        data_src,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clr_stat,
    output logic [DATA_W-1:0] rdata,
    input  logic              kbd_stb,
    input  logic [CHAR_W-1:0] kbd_char,
    output logic              term_valid,
    output logic [CHAR_W-1:0] term_char,
    input  logic              term_ready
);

    term_state_e       state_q, state_d;
    logic [CHAR_W-1:0] term_char_q, term_char_d;
    logic              ovr_q, ovr_d;
    logic              drop_q, drop_d;

    logic              rd, wr, rd_data, wr_term;
    logic [CHAR_W-1:0] fifo_head;
    logic              fifo_full, fifo_empty, fifo_lost;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [FB_ST_W-1:0] status;
    logic              unused_ok;

    assign rd      = dev_sel & rd_en & (data_src != FB_SEL_MEM);
    assign wr      = dev_sel & wr_en & (data_src != FB_SEL_MEM);
    assign rd_data = rd & (data_src == FB_SEL_DATA);
    assign wr_term = wr & (data_src == FB_SEL_TERM);

    fb_io_fifo #(
        .CHAR_W     (CHAR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (kbd_stb),
        .pop   (rd_data),
        .din   (kbd_char),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .lost  (fifo_lost)
    );

    assign term_valid = (state_q == TERM_BUSY);
    assign term_char  = term_char_q;

    always_comb begin
        status              = '0;
        status[FB_ST_AVAIL] = ~fifo_empty;
        status[FB_ST_OVR]   = ovr_q;
        status[FB_ST_BUSY]  = term_valid;
        status[FB_ST_DROP]  = drop_q;
    end

    // Terminal FSM. A write while BUSY is dropped even in the accept
    // cycle, so the character just accepted is never overwritten in flight.
    always_comb begin
        state_d     = state_q;
        term_char_d = term_char_q;
        drop_d      = drop_q & ~clr_stat;
        case (state_q)
            TERM_IDLE: begin
                if (wr_term) begin
                    state_d     = TERM_BUSY;
                    term_char_d = wdata[CHAR_W-1:0];
                end
            end
            TERM_BUSY: begin
                if (wr_term) drop_d = 1'b1;
                if (term_ready) state_d = TERM_IDLE;
            end
            default: state_d = TERM_IDLE;
        endcase
        // New overflow beats a coincident clear.
        ovr_d = (ovr_q & ~clr_stat) | fifo_lost;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= TERM_IDLE;
            term_char_q <= '0;
            ovr_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            term_char_q <= term_char_d;
            ovr_q       <= ovr_d;
            drop_q      <= drop_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            case (data_src)
                FB_SEL_STAT: rdata[FB_ST_W-1:0] = status;
                FB_SEL_DATA: rdata[CHAR_W-1:0]  = fifo_empty ? '0 : fifo_head;
                FB_SEL_TERM: rdata[CHAR_W-1:0]  = term_char_q;
                default:     rdata = '0;
            endcase
        end
    end

    // Upper store bits and occupancy count are not needed here.
    assign unused_ok = ^{wdata[DATA_W-1:CHAR_W], fifo_count, fifo_full};

endmodule

// File: tb/tb_fb_io_dev.sv
module tb_fb_io_dev;

    localparam int DATA_W = 32;
    localparam int CHAR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              dev_sel;
    logic [1:0]        data_src;
    logic              rd_en, wr_en;
    logic [DATA_W-1:0] wdata;
    logic              clr_stat;
    logic [DATA_W-1:0] rdata;
    logic              kbd_stb;
    logic [CHAR_W-1:0] kbd_char;
    logic              term_valid;
    logic [CHAR_W-1:0] term_char;
    logic              term_ready;

    int checks = 0;
    int errors = 0;

    fb_io_dev #(.DATA_W(DATA_W), .CHAR_W(CHAR_W), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .dev_sel    (dev_sel),
        .data_src   (data_src),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .wdata      (wdata),
        .clr_stat   (clr_stat),
        .rdata      (rdata),
        .kbd_stb    (kbd_stb),
        .kbd_char   (kbd_char),
        .term_valid (term_valid),
        .term_char  (term_char),
        .term_ready (term_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              rst;
        logic              dev_sel;
        logic [1:0]        src;
        logic              rd;
        logic              wr;
        logic [7:0]        wd;
        logic              clr;
        logic              kstb;
        logic [7:0]        kch;
        logic              trdy;
        logic [DATA_W-1:0] exp_rdata;
        logic              exp_tv;
        logic [7:0]        exp_tc;
    } vec_t;

    vec_t vecs[$];

    // Shorthand rows with dev_sel=1, rst=0.
    function automatic vec_t v(logic [1:0] src, logic rd, logic wr, logic [7:0] wd,
                               logic clr, logic kstb, logic [7:0] kch, logic trdy,
                               logic [31:0] er, logic etv, logic [7:0] etc_);
        vec_t r;
        r.rst = 1'b0; r.dev_sel = 1'b1; r.src = src; r.rd = rd; r.wr = wr; r.wd = wd;
        r.clr = clr; r.kstb = kstb; r.kch = kch; r.trdy = trdy;
        r.exp_rdata = er; r.exp_tv = etv; r.exp_tc = etc_;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t r);
        rst = r.rst; dev_sel = r.dev_sel; data_src = r.src; rd_en = r.rd; wr_en = r.wr;
        wdata = {24'h0, r.wd}; clr_stat = r.clr; kbd_stb = r.kstb; kbd_char = r.kch;
        term_ready = r.trdy;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; dev_sel = 1'b0; data_src = 2'b11; rd_en = 1'b0; wr_en = 1'b0;
        wdata = '0; clr_stat = 1'b0; kbd_stb = 1'b0; kbd_char = '0; term_ready = 1'b0;
    endtask

    initial begin
        vec_t r;
        int wait_cnt;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // reset state
        vecs.push_back(v(2'b00,1,0,8'h00,0,0,8'h00,0, 32'h0,0,8'h00));   // 0 STATUS=0
        vecs.push_back(v(2'b10,1,0,8'h00,0,0,8'h00,0, 32'h0,0,8'h00));   // 1 TERM=0
        // test 1
        vecs.push_back(v(2'b00,0,0,8'h00,0,1,8'h41,0, 32'h0,0,8'h00));   // 2
        vecs.push_back(v(2'b00,1,0,8'h00,0,0,8'h00,0, 32'h1,0,8'h00));   // 3
        vecs.push_back(v(2'b01,1,0,8'h00,0,0,8'h00,0, 32'h41,0,8'h00));  // 4
        vecs.push_back(v(2'b00,1,0,8'h00,0,0,8'h00,0, 32'h0,0,8'h00));   // 5
        vecs.push_back(v(2'b01,1,0,8'h00,0,0,8'h00,0, 32'h0,0,8'h00));   // 6 empty read
        // test 2: five pushes into depth 4
        for (int i = 0; i < 5; i++)
            vecs.push_back(v(2'b00,0,0,8'h00,0,1,8'(8'h30+i),0, 32'h0,0,8'h00));
        vecs.push_back(v(2'b00,1,0,8'h00,0,0,8'h00,0, 32'h3,0,8'h00));   // 12
        for (int i = 0; i < 4; i++)
            vecs.push_back(v(2'b01,1,0,8'h00,0,0,8'h00,0, 32'(8'h30+i),0,8'h00));
        vecs.push_back(v(2'b01,1,0,8'h00,0,0,8'h00,0, 32'h0,0,8'h00));   // 17 fifth read
        vecs.push_back(v(2'b00,1,0,8'h00,0,0,8'h00,0, 32'h2,0,8'h00));   // 18 ovr sticky
        vecs.push_back(v(2'b00,0,0,8'h00,1,0,8'h00,0, 32'h0,0,8'h00));   // 19 clr
        vecs.push_back(v(2'b00,1,0,8'h00,0,0,8'h00,0, 32'h0,0,8'h00));   // 20
        // test 3: push+pop on full
        for (int i = 0; i < 4; i++)
            vecs.push_back(v(2'b00,0,0,8'h00,0,1,8'(8'h60+i),0, 32'h0,0,8'h00));
        vecs.push_back(v(2'b01,1,0,8'h00,0,1,8'h55,0, 32'h60,0,8'h00));  // 25
        vecs.push_back(v(2'b00,1,0,8'h00,0,0,8'h00,0, 32'h1,0,8'h00));   // 26 ovr=0
        vecs.push_back(v(2'b01,1,0,8'h00,0,0,8'h00,0, 32'h61,0,8'h00));
        vecs.push_back(v(2'b01,1,0,8'h00,0,0,8'h00,0, 32'h62,0,8'h00));
        vecs.push_back(v(2'b01,1,0,8'h00,0,0,8'h00,0, 32'h63,0,8'h00));
        vecs.push_back(v(2'b01,1,0,8'h00,0,0,8'h00,0, 32'h55,0,8'h00));
        vecs.push_back(v(2'b01,1,0,8'h00,0,0,8'h00,0, 32'h0,0,8'h00));   // 31 count was 4
        vecs.push_back(v(2'b00,1,0,8'h00,0,0,8'h00,0, 32'h0,0,8'h00));   // 32
        // push+pop on empty
        vecs.push_back(v(2'b01,1,0,8'h00,0,1,8'h77,0, 32'h0,0,8'h00));   // 33
        vecs.push_back(v(2'b00,1,0,8'h00,0,0,8'h00,0, 32'h1,0,8'h00));
        vecs.push_back(v(2'b01,1,0,8'h00,0,0,8'h00,0, 32'h77,0,8'h00));  // 35
        // test 4: terminal
        vecs.push_back(v(2'b10,0,1,8'h48,0,0,8'h00,0, 32'h0,0,8'h00));   // 36
        vecs.push_back(v(2'b00,1,0,8'h00,0,0,8'h00,0, 32'h4,1,8'h48));
        vecs.push_back(v(2'b10,1,0,8'h00,0,0,8'h00,0, 32'h48,1,8'h48));
        vecs.push_back(v(2'b00,0,0,8'h00,0,0,8'h00,0, 32'h0,1,8'h48));
        vecs.push_back(v(2'b10,0,1,8'h49,0,0,8'h00,0, 32'h0,1,8'h48));   // 40 write while busy
        vecs.push_back(v(2'b00,1,0,8'h00,0,0,8'h00,0, 32'hC,1,8'h48));
        vecs.push_back(v(2'b00,0,0,8'h00,0,0,8'h00,1, 32'h0,1,8'h48));   // 42 accept
        vecs.push_back(v(2'b00,1,0,8'h00,0,0,8'h00,0, 32'h8,0,8'h48));   // 43 char holds
        // write in accept cycle is dropped
        vecs.push_back(v(2'b10,0,1,8'h50,0,0,8'h00,0, 32'h0,0,8'h48));
        vecs.push_back(v(2'b00,1,0,8'h00,0,0,8'h00,0, 32'hC,1,8'h50));
        vecs.push_back(v(2'b00,0,0,8'h00,1,0,8'h00,0, 32'h0,1,8'h50));   // 46 clr drop
        vecs.push_back(v(2'b00,1,0,8'h00,0,0,8'h00,0, 32'h4,1,8'h50));
        vecs.push_back(v(2'b10,0,1,8'h51,0,0,8'h00,1, 32'h0,1,8'h50));   // 48 accept + write
        vecs.push_back(v(2'b00,1,0,8'h00,0,0,8'h00,0, 32'h8,0,8'h50));
        vecs.push_back(v(2'b10,1,0,8'h00,0,0,8'h00,0, 32'h50,0,8'h50));  // 50
        // test 5: clr_stat and set-wins
        for (int i = 0; i < 5; i++)
            vecs.push_back(v(2'b00,0,0,8'h00,0,1,8'(8'h10+i),0, 32'h0,0,8'h50));
        vecs.push_back(v(2'b00,1,0,8'h00,0,0,8'h00,0, 32'hB,0,8'h50));   // 56
        vecs.push_back(v(2'b00,0,0,8'h00,1,0,8'h00,0, 32'h0,0,8'h50));
        vecs.push_back(v(2'b00,1,0,8'h00,0,0,8'h00,0, 32'h1,0,8'h50));
        vecs.push_back(v(2'b00,0,0,8'h00,1,1,8'h15,0, 32'h0,0,8'h50));   // 59 clr + overflow
        vecs.push_back(v(2'b00,1,0,8'h00,0,0,8'h00,0, 32'h3,0,8'h50));
        vecs.push_back(v(2'b10,0,1,8'h61,0,0,8'h00,0, 32'h0,0,8'h50));   // 61
        vecs.push_back(v(2'b10,0,1,8'h62,1,0,8'h00,0, 32'h0,1,8'h61));   // 62 clr + drop
        vecs.push_back(v(2'b00,1,0,8'h00,0,0,8'h00,0, 32'hD,1,8'h61));
        // test 6: non-device accesses
        vecs.push_back(v(2'b11,1,1,8'h99,0,0,8'h00,0, 32'h0,1,8'h61));   // 64
        r = v(2'b01,1,0,8'h00,0,0,8'h00,0, 32'h0,1,8'h61); r.dev_sel = 1'b0; vecs.push_back(r);
        r = v(2'b10,0,1,8'h77,0,0,8'h00,0, 32'h0,1,8'h61); r.dev_sel = 1'b0; vecs.push_back(r);
        vecs.push_back(v(2'b00,1,0,8'h00,0,0,8'h00,0, 32'hD,1,8'h61));   // 67
        vecs.push_back(v(2'b01,1,0,8'h00,0,0,8'h00,0, 32'h10,1,8'h61));
        vecs.push_back(v(2'b10,1,0,8'h00,0,0,8'h00,0, 32'h61,1,8'h61));
        vecs.push_back(v(2'b01,1,0,8'h00,0,0,8'h00,0, 32'h11,1,8'h61));  // 70 two left
        r = v(2'b00,1,0,8'h00,0,0,8'h00,0, 32'hD,1,8'h61); r.rst = 1'b1; vecs.push_back(r);
        vecs.push_back(v(2'b00,1,0,8'h00,0,0,8'h00,0, 32'h0,0,8'h00));   // 72 after reset
        vecs.push_back(v(2'b10,1,0,8'h00,0,0,8'h00,0, 32'h0,0,8'h00));
        vecs.push_back(v(2'b01,1,0,8'h00,0,0,8'h00,0, 32'h0,0,8'h00));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("row%0d rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("row%0d term_valid", i), 32'(term_valid), 32'(vecs[i].exp_tv));
            chk($sformatf("row%0d term_char", i), 32'(term_char), 32'(vecs[i].exp_tc));
            @(posedge clk);
            @(negedge clk);
        end

        // Hand sequence: character held across a long stall, then released.
        idle_inputs();
        dev_sel = 1'b1; data_src = 2'b10; wr_en = 1'b1; wdata = 32'h5A;
        @(posedge clk); @(negedge clk);
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("stall%0d term_valid", i), 32'(term_valid), 32'h1);
            chk($sformatf("stall%0d term_char", i), 32'(term_char), 32'h5A);
            @(posedge clk); @(negedge clk);
        end
        term_ready = 1'b1;
        wait_cnt = 0;
        @(posedge clk); @(negedge clk);
        while (term_valid && wait_cnt < 4) begin
            wait_cnt++;
            @(posedge clk); @(negedge clk);
        end
        chk("release term_valid", 32'(term_valid), 32'h0);
        chk("release latency", 32'(wait_cnt), 32'h0);
        chk("release term_char", 32'(term_char), 32'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
